// File: rtl/ifu_idu_queue_if.sv
// IFU->IDU queue bundle: fetch push side, decode pop side, flush, occupancy.
// slave = queue, master = the fetch/decode environment driving it.
interface ifu_idu_queue_if #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_inst;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_inst;
  logic            flush;
  logic [CW-1:0]   count;

  modport slave (
    input  in_valid, in_pc, in_inst,
    input  out_ready, flush,
    output in_ready, out_valid,
    output out_pc, out_inst, count
  );

  modport master (
    output in_valid, in_pc, in_inst,
    output out_ready, flush,
    input  in_ready, out_valid,
    input  out_pc, out_inst, count
  );
endinterface

// File: rtl/ifu_idu_queue.sv
// In-order {pc,inst} queue between fetch and decode, with redirect flush.
// Ports: clk, rst (async active-low), q (ifu_idu_queue_if.slave).
module ifu_idu_queue #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input logic            clk,
  input logic            rst,
  ifu_idu_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h00000013);

  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [XLEN-1:0] inst_mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt;
  logic            empty;
  logic            full;
  logic            push;
  logic            pop;

  assign empty = (cnt == '0);
  assign full  = (cnt == FULL);

  // Full refuses a push even if a pop happens the same cycle.
  assign q.in_ready  = !q.flush && !full;
  assign q.out_valid = !q.flush && !empty;

  assign push = q.in_valid && q.in_ready;
  assign pop  = q.out_valid && q.out_ready;

  assign q.out_pc   = empty ? '0  : pc_mem[rd_ptr];
  assign q.out_inst = empty ? NOP : inst_mem[rd_ptr];
  assign q.count    = cnt;

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= q.in_pc;
      inst_mem[wr_ptr] <= q.in_inst;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (q.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case (1'b1)
        (push && !pop): cnt <= cnt + CW'(1);
        (pop && !push): cnt <= cnt - CW'(1);
        default:        cnt <= cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_ifu_idu_queue.sv
// Bench for ifu_idu_queue (DEPTH=2): vector table, scoreboard of pushed
// entries checked at the head, streaming run and async reset sequence.
module tb_ifu_idu_queue;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  ifu_idu_queue_if #(.DEPTH(2), .XLEN(32)) bus ();

  ifu_idu_queue #(.DEPTH(2), .XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .q   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ordy;
    logic        fl;
    logic        e_ir;
    logic        e_ov;
    logic [1:0]  e_cnt;
  } vec_t;

  vec_t        tab [12];
  logic [63:0] sb [$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle from a negedge, check before the edge, advance model.
  task automatic step(input logic iv, input logic [31:0] pc,
                      input logic [31:0] inst, input logic ordy,
                      input logic fl, input logic use_tab,
                      input logic e_ir, input logic e_ov,
                      input logic [1:0] e_cnt);
    int          mc;
    logic        eir;
    logic        eov;
    logic [63:0] hd;
    bus.in_valid  = iv;
    bus.in_pc     = pc;
    bus.in_inst   = inst;
    bus.out_ready = ordy;
    bus.flush     = fl;
    #1;
    mc  = sb.size();
    eir = !fl && (mc != 2);
    eov = !fl && (mc != 0);
    hd  = (mc != 0) ? sb[0] : {32'h0, 32'h00000013};
    chk("in_ready", 32'(bus.in_ready), 32'(eir));
    chk("out_valid", 32'(bus.out_valid), 32'(eov));
    chk("count", 32'(bus.count), 32'(mc));
    chk("out_pc", bus.out_pc, hd[63:32]);
    chk("out_inst", bus.out_inst, hd[31:0]);
    if (use_tab) begin
      chk("tab_in_ready", 32'(bus.in_ready), 32'(e_ir));
      chk("tab_out_valid", 32'(bus.out_valid), 32'(e_ov));
      chk("tab_count", 32'(bus.count), 32'(e_cnt));
    end
    if (fl) begin
      sb.delete();
    end else begin
      if (eov && ordy) void'(sb.pop_front());
      if (eir && iv) sb.push_back({pc, inst});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    tab[0]  = '{1'b1, 32'h80000000, 32'h00100093, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
    tab[1]  = '{1'b1, 32'h80000004, 32'h00200113, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1};
    tab[2]  = '{1'b1, 32'h80000008, 32'h00300193, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2};
    tab[3]  = '{1'b1, 32'h80000008, 32'h00300193, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2};
    tab[4]  = '{1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 2'd1};
    tab[5]  = '{1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 2'd0};
    tab[6]  = '{1'b1, 32'h80000008, 32'h00300193, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
    tab[7]  = '{1'b1, 32'h8000000c, 32'h00400213, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1};
    tab[8]  = '{1'b1, 32'h80000010, 32'h00500293, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2};
    tab[9]  = '{1'b1, 32'h80000100, 32'h10000513, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0};
    tab[10] = '{1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 2'd1};
    tab[11] = '{1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 2'd0};

    bus.in_valid  = 1'b0;
    bus.in_pc     = '0;
    bus.in_inst   = '0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;

    #2;
    chk("rst_hold_count", 32'(bus.count), 32'd0);
    chk("rst_hold_valid", 32'(bus.out_valid), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_inst", bus.out_inst, 32'h00000013);
    chk("rst_out_pc", bus.out_pc, 32'h0);
    @(negedge clk);

    for (int i = 0; i < 12; i++)
      step(tab[i].iv, tab[i].pc, tab[i].inst, tab[i].ordy, tab[i].fl,
           1'b1, tab[i].e_ir, tab[i].e_ov, tab[i].e_cnt);

    // Streaming: one in, one out per cycle; count settles at 1.
    for (int i = 0; i < 22; i++) begin
      step(i < 20, 32'h80000000 + 32'(4 * i), 32'h00000093 + 32'(i << 7),
           1'b1, 1'b0, (i >= 1 && i < 20), 1'b1, 1'b1, 2'd1);
    end

    // Async reset mid-stream with one entry held.
    step(1'b1, 32'h80000200, 32'h00600313, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    chk("pre_arst_count", 32'(bus.count), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_count", 32'(bus.count), 32'd0);
    chk("arst_out_inst", bus.out_inst, 32'h00000013);
    sb.delete();
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 32'h80000300, 32'h00700393, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
